// File: rtl/inst_sram_bridge64.sv
// rtl/inst_sram_bridge64.sv - 64-bit fetch line bridge over a 32-bit SRAM-like read port
// Optional one-line reuse buffer enabled by defining INST_BRIDGE_LINE_BUF_EN.
module inst_sram_bridge64 (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [63:0] inst_rdata,
  input  logic        flush,
  input  logic        line_inv,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LO_REQ  = 3'd1,
    LO_WAIT = 3'd2,
    HI_REQ  = 3'd3,
    HI_WAIT = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t      state, state_d;
  logic        cancel, cancel_d;
  logic [28:0] line;
  logic        accept;
  logic        buf_hit;
  logic        hi_done;
  logic        unused_bits;

`ifdef INST_BRIDGE_LINE_BUF_EN
  logic        buf_valid;
  logic [28:0] buf_tag;
  logic [63:0] buf_data;

  assign buf_hit     = buf_valid && (buf_tag == inst_addr[31:3]);
  assign unused_bits = ^inst_addr[2:0];
`else
  assign buf_hit     = 1'b0;
  assign unused_bits = ^{line_inv, inst_addr[2:0]};
`endif

  assign hi_done = (state == HI_WAIT) && mem_data_ok;

  always_comb begin
    state_d      = state;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    mem_req      = 1'b0;
    mem_addr     = 32'd0;
    accept       = 1'b0;
    case (state)
      IDLE: begin
        inst_addr_ok = !flush;
        if (inst_req && !flush) begin
          accept  = 1'b1;
          state_d = buf_hit ? RESP : LO_REQ;
        end
      end
      LO_REQ: begin
        mem_req  = 1'b1;
        mem_addr = {line, 3'b000};
        if (mem_addr_ok) state_d = LO_WAIT;
      end
      LO_WAIT: begin
        if (mem_data_ok) state_d = HI_REQ;
      end
      HI_REQ: begin
        mem_req  = 1'b1;
        mem_addr = {line, 3'b100};
        if (mem_addr_ok) state_d = HI_WAIT;
      end
      HI_WAIT: begin
        if (mem_data_ok) state_d = RESP;
      end
      RESP: begin
        inst_data_ok = !cancel && !flush;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A cancelled fetch still drains its memory reads; only the strobe is lost.
    if (state_d == IDLE)
      cancel_d = 1'b0;
    else if (flush && (state != IDLE))
      cancel_d = 1'b1;
    else
      cancel_d = cancel;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cancel     <= 1'b0;
      line       <= 29'd0;
      inst_rdata <= 64'd0;
    end else begin
      state  <= state_d;
      cancel <= cancel_d;
      if (accept) line <= inst_addr[31:3];
      if ((state == LO_WAIT) && mem_data_ok) inst_rdata[63:32] <= mem_rdata;
      if (hi_done) inst_rdata[31:0] <= mem_rdata;
`ifdef INST_BRIDGE_LINE_BUF_EN
      if (accept && buf_hit) inst_rdata <= buf_data;
`endif
    end
  end

`ifdef INST_BRIDGE_LINE_BUF_EN
  // Invalidation takes priority over a fill landing in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_valid <= 1'b0;
      buf_tag   <= 29'd0;
      buf_data  <= 64'd0;
    end else if (line_inv) begin
      buf_valid <= 1'b0;
    end else if (hi_done) begin
      buf_valid <= 1'b1;
      buf_tag   <= line;
      buf_data  <= {inst_rdata[63:32], mem_rdata};
    end
  end
`endif

endmodule

// File: tb/tb_inst_sram_bridge64.sv
// tb/tb_inst_sram_bridge64.sv - scoreboard bench for inst_sram_bridge64
module tb_inst_sram_bridge64;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = 32'd0;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [63:0] inst_rdata;
  logic        flush = 1'b0;
  logic        line_inv = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_addr_ok = 1'b0;
  logic        mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int n_checks = 0;
  int n_fail = 0;

  logic [63:0] expq[$];
  logic [31:0] addrq[$];

  bit          mem_random = 1'b0;
  int          hi_stall = 0;
  bit          m_buf_valid = 1'b0;
  logic [28:0] m_buf_tag = 29'd0;

  inst_sram_bridge64 dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .flush(flush), .line_inv(line_inv),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h1FC0_0000) return 32'h2408_0001;
    if (a == 32'h1FC0_0004) return 32'h2409_0002;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Memory responder: random or fixed stalls, data 1..3 cycles after acceptance.
  initial begin
    bit          pending = 0;
    int          pdelay = 0;
    logic [31:0] paddr = 0;
    bit          have_prev = 0;
    logic [31:0] prev_addr = 0;
    bit          go;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        pending = 0; have_prev = 0;
        mem_addr_ok = 0; mem_data_ok = 0;
        continue;
      end
      mem_data_ok = 0;
      if (pending) begin
        if (pdelay == 0) begin
          mem_data_ok = 1;
          mem_rdata = mem_fn(paddr);
          pending = 0;
        end else pdelay--;
      end
      if (mem_req && have_prev) check("mem_addr_stable", mem_addr, prev_addr);
      mem_addr_ok = 0;
      if (mem_req) begin
        if (mem_random) go = ($urandom_range(0, 3) != 0);
        else if (mem_addr[2] && hi_stall > 0) begin hi_stall--; go = 0; end
        else go = 1;
        if (go) begin
          mem_addr_ok = 1;
          if (addrq.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_mem_req: got addr %h expected none", mem_addr);
          end else check("mem_addr", mem_addr, addrq.pop_front());
          pending = 1;
          paddr = mem_addr;
          pdelay = mem_random ? $urandom_range(0, 2) : 0;
          have_prev = 0;
        end else begin
          have_prev = 1;
          prev_addr = mem_addr;
        end
      end else have_prev = 0;
    end
  end

  // Response monitor: every strobe must match the oldest expected line.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (resetn && inst_data_ok) begin
        if (expq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_strobe: got data %h expected no strobe", inst_rdata);
        end else check("inst_rdata", inst_rdata, expq.pop_front());
      end
    end
  end

  // One fetch; flush_at>0 pulses flush that many cycles after acceptance.
  task automatic fetch(input logic [31:0] addr, input int flush_at, output int end_cyc);
    logic [28:0] line;
    bit hit, done, cancelled;
    int waited, cyc, lat_exp;
    line = addr[31:3];
`ifdef INST_BRIDGE_LINE_BUF_EN
    hit = m_buf_valid && (m_buf_tag == line);
`else
    hit = 0;
`endif
    lat_exp = hit ? 1 : (mem_random ? -1 : 5 + hi_stall);
    end_cyc = -1;
    @(negedge clk);
    inst_req = 1; inst_addr = addr; flush = 0;
    #1;
    waited = 0;
    while (!inst_addr_ok && waited < 50) begin
      @(negedge clk); #1; waited++;
    end
    if (!inst_addr_ok) begin
      fail_now("accept_timeout");
      inst_req = 0;
      return;
    end
    expq.push_back({mem_fn({line, 3'b000}), mem_fn({line, 3'b100})});
    if (!hit) begin
      addrq.push_back({line, 3'b000});
      addrq.push_back({line, 3'b100});
    end
    cyc = 0; done = 0; cancelled = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      inst_req = 0;
      cyc++;
      flush = (cyc == flush_at);
      if (flush && !cancelled) begin
        cancelled = 1;
        void'(expq.pop_back());
      end
      #1;
      if (inst_data_ok) done = 1;
      else if (cancelled && !flush && inst_addr_ok) done = 1;
    end
    flush = 0;
    if (!done) fail_now("fetch_timeout");
    else begin
      end_cyc = cyc;
      if (!cancelled && lat_exp >= 0) check("latency", cyc, lat_exp);
    end
    if (!hit) begin
      m_buf_valid = 1;
      m_buf_tag = line;
    end
  endtask

  task automatic pulse_inv();
    @(negedge clk); line_inv = 1;
    @(negedge clk); line_inv = 0;
`ifdef INST_BRIDGE_LINE_BUF_EN
    m_buf_valid = 0;
`endif
  endtask

  initial begin
    int e;
    logic [31:0] a;

    @(negedge clk); #1;
    check("rst_addr_ok", inst_addr_ok, 1);
    check("rst_data_ok", inst_data_ok, 0);
    check("rst_rdata", inst_rdata, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    @(negedge clk); #3 resetn = 1;

    // Basic miss, zero wait.
    fetch(32'h1FC0_0004, 0, e);
    #2 check("basic_rdata", inst_rdata, 64'h2408_0001_2409_0002);

    // High-word request stalled three cycles.
    hi_stall = 3;
    fetch(32'h1FC0_0004, 0, e);

    // Flush in LO_WAIT: reads drain, no strobe, idle again after RESP.
    fetch(32'h0000_1230, 2, e);
    check("flush_idle_cycle", e, 6);
    check("flush_reads_done", addrq.size(), 0);

    // Flush together with a request blocks acceptance.
    @(negedge clk); flush = 1; inst_req = 1; inst_addr = 32'h0000_4440;
    repeat (3) begin
      #1 check("flush_block_ok", inst_addr_ok, 0);
      check("flush_block_req", mem_req, 0);
      @(negedge clk);
    end
    inst_req = 0; flush = 0;
    #1 check("flush_block_after", mem_req, 0);

    // Reset during HI_WAIT.
    @(negedge clk); inst_req = 1; inst_addr = 32'h0040_1238;
    #1 check("rst_accept", inst_addr_ok, 1);
    addrq.push_back(32'h0040_1238);
    addrq.push_back(32'h0040_123C);
    repeat (4) begin @(negedge clk); inst_req = 0; end
    #3 resetn = 0;
    #1;
    check("mid_rst_addr_ok", inst_addr_ok, 1);
    check("mid_rst_data_ok", inst_data_ok, 0);
    check("mid_rst_rdata", inst_rdata, 0);
    check("mid_rst_mem_req", mem_req, 0);
    check("mid_rst_mem_addr", mem_addr, 0);
    check("mid_rst_reads", addrq.size(), 0);
    repeat (2) @(negedge clk);
    #3 resetn = 1;
    m_buf_valid = 0;
    fetch(32'h0040_1238, 0, e);

    // Repeat fetch of the same line; reuse buffer hits when present.
    fetch(32'h8000_0000, 0, e);
    fetch(32'h8000_0004, 0, e);
    pulse_inv();
    fetch(32'h8000_0000, 0, e);

    // Randomized traffic with random memory timing.
    mem_random = 1;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: a = 32'h8000_0000;
        1: a = 32'h8000_0008;
        default: a = $urandom;
      endcase
      a = a | $urandom_range(0, 7);
      fetch(a, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : 0, e);
      if ($urandom_range(0, 5) == 0) pulse_inv();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("expq_empty", expq.size(), 0);
    check("addrq_empty", addrq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
